// File: rtl/riscv_pkg.sv
// Base RISC-V types shared across the core: register index and datapath word.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef logic [XLEN-1:0]  data_t;
    typedef logic [REG_W-1:0] reg_t;

endpackage

// File: rtl/tortoise_pkg.sv
// Core-level configuration constants and commit-stage types.
package tortoise_pkg;

    import riscv_pkg::*;

    localparam int unsigned COMMIT_DEPTH     = 4;
    localparam int unsigned GPREG_READ_PORTS = 3;

    typedef struct packed {
        data_t pc;
        logic  we;
        reg_t  rd;
        data_t result;
        logic  exc;
        data_t cause;
    } commit_entry_t;

    typedef enum logic {
        RUN        = 1'b0,
        WAIT_FLUSH = 1'b1
    } commit_state_e;

endpackage

// File: rtl/commit_bypass.sv
// Bypass lookup for one read port: youngest matching commit-queue entry wins.
module commit_bypass
    import riscv_pkg::*;
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH = COMMIT_DEPTH
) (
    input  logic [DEPTH-1:0]                cand_i,
    input  logic [DEPTH-1:0][REG_W-1:0]     rd_i,
    input  logic [DEPTH-1:0][XLEN-1:0]      result_i,
    input  logic [$clog2(DEPTH)-1:0]        tail_i,
    input  reg_t                            reg_i,
    output logic                            hit_o,
    output data_t                           data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from tail-1 backwards; the first candidate with a matching rd is the youngest
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_i - PTR_W'(k + 1);
            if (!hit_o && cand_i[idx] && (rd_i[idx] == reg_i)) begin
                hit_o  = 1'b1;
                data_o = result_i[idx];
            end
        end
    end

endmodule

// File: rtl/commit_queue.sv
// In-order commit queue feeding the GP register-file write port, with precise exceptions.
// Optional bypass search over queued results is built when COMMIT_QUEUE_BYPASS_EN is defined.
module commit_queue
    import riscv_pkg::*;
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH         = COMMIT_DEPTH,
    parameter int unsigned NR_READ_PORTS = GPREG_READ_PORTS
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic                                 debug_mode_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [XLEN-1:0]                      pc_i,
    input  logic                                 we_i,
    input  logic [REG_W-1:0]                     rd_i,
    input  logic [XLEN-1:0]                      result_i,
    input  logic                                 exc_i,
    input  logic [XLEN-1:0]                      cause_i,
    output logic                                 w_en_o,
    output logic [REG_W-1:0]                     w_reg_o,
    output logic [XLEN-1:0]                      w_data_o,
    output logic                                 commit_o,
    output logic [XLEN-1:0]                      commit_pc_o,
    output logic                                 exc_o,
    output logic [XLEN-1:0]                      exc_cause_o,
    output logic [XLEN-1:0]                      exc_pc_o,
    input  logic [NR_READ_PORTS-1:0][REG_W-1:0]  byp_reg_i,
    output logic [NR_READ_PORTS-1:0]             byp_hit_o,
    output logic [NR_READ_PORTS-1:0][XLEN-1:0]   byp_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    commit_entry_t     entries_q [DEPTH];
    commit_entry_t     entries_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    commit_state_e     state_q, state_d;

    commit_entry_t     head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // State, pointers, occupancy and storage registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    // Enqueue/retire decisions, next state and retirement outputs straight from the head entry
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        entries_d   = entries_q;
        ready_o     = 1'b0;
        w_en_o      = 1'b0;
        w_reg_o     = '0;
        w_data_o    = '0;
        commit_o    = 1'b0;
        commit_pc_o = '0;
        exc_o       = 1'b0;
        exc_cause_o = '0;
        exc_pc_o    = '0;
        push        = 1'b0;
        pop         = 1'b0;

        head  = entries_q[rd_ptr_q];
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);

        ready_o = rst_ni && (state_q == RUN) && !full;
        push    = valid_i && ready_o;

        if ((state_q == RUN) && !empty && !debug_mode_i) begin
            pop = 1'b1;
            if (head.exc) begin
                exc_o       = 1'b1;
                exc_cause_o = head.cause;
                exc_pc_o    = head.pc;
                state_d     = WAIT_FLUSH;
            end else begin
                commit_o    = 1'b1;
                commit_pc_o = head.pc;
                if (head.we && (head.rd != '0)) begin
                    w_en_o   = 1'b1;
                    w_reg_o  = head.rd;
                    w_data_o = head.result;
                end
            end
        end

        if (push) begin
            entries_d[wr_ptr_q] = '{pc: pc_i, we: we_i, rd: rd_i, result: result_i,
                                    exc: exc_i, cause: cause_i};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flush discards everything, including anything accepted or retired this cycle
        if (flush_i) begin
            state_d  = RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

`ifdef COMMIT_QUEUE_BYPASS_EN
    logic [DEPTH-1:0]             byp_cand;
    logic [DEPTH-1:0][REG_W-1:0]  byp_rd;
    logic [DEPTH-1:0][XLEN-1:0]   byp_res;
    logic [PTR_W-1:0]             byp_age;

    // Mark slots that hold a live, non-faulting write to a real register
    always_comb begin
        byp_cand = '0;
        byp_rd   = '0;
        byp_res  = '0;
        byp_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            byp_age     = PTR_W'(i) - rd_ptr_q;
            byp_cand[i] = ({1'b0, byp_age} < count_q) && entries_q[i].we &&
                          !entries_q[i].exc && (entries_q[i].rd != '0);
            byp_rd[i]   = entries_q[i].rd;
            byp_res[i]  = entries_q[i].result;
        end
    end

    for (genvar p = 0; p < NR_READ_PORTS; p++) begin : g_byp
        commit_bypass #(.DEPTH(DEPTH)) u_bypass (
            .cand_i   (byp_cand),
            .rd_i     (byp_rd),
            .result_i (byp_res),
            .tail_i   (wr_ptr_q),
            .reg_i    (byp_reg_i[p]),
            .hit_o    (byp_hit_o[p]),
            .data_o   (byp_data_o[p])
        );
    end
`else
    logic unused_byp_reg;

    assign byp_hit_o      = '0;
    assign byp_data_o     = '0;
    assign unused_byp_reg = ^byp_reg_i;
`endif

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue with a queue-based reference model checked every cycle.
module tb_commit_queue;

    import riscv_pkg::*;
    import tortoise_pkg::*;

    localparam int unsigned DEPTH = COMMIT_DEPTH;
    localparam int unsigned NRP   = GPREG_READ_PORTS;

    logic                        clk_i;
    logic                        rst_ni;
    logic                        flush_i;
    logic                        debug_mode_i;
    logic                        valid_i;
    logic                        ready_o;
    logic [XLEN-1:0]             pc_i;
    logic                        we_i;
    logic [REG_W-1:0]            rd_i;
    logic [XLEN-1:0]             result_i;
    logic                        exc_i;
    logic [XLEN-1:0]             cause_i;
    logic                        w_en_o;
    logic [REG_W-1:0]            w_reg_o;
    logic [XLEN-1:0]             w_data_o;
    logic                        commit_o;
    logic [XLEN-1:0]             commit_pc_o;
    logic                        exc_o;
    logic [XLEN-1:0]             exc_cause_o;
    logic [XLEN-1:0]             exc_pc_o;
    logic [NRP-1:0][REG_W-1:0]   byp_reg_i;
    logic [NRP-1:0]              byp_hit_o;
    logic [NRP-1:0][XLEN-1:0]    byp_data_o;

    commit_queue #(.DEPTH(DEPTH), .NR_READ_PORTS(NRP)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .debug_mode_i (debug_mode_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .pc_i         (pc_i),
        .we_i         (we_i),
        .rd_i         (rd_i),
        .result_i     (result_i),
        .exc_i        (exc_i),
        .cause_i      (cause_i),
        .w_en_o       (w_en_o),
        .w_reg_o      (w_reg_o),
        .w_data_o     (w_data_o),
        .commit_o     (commit_o),
        .commit_pc_o  (commit_pc_o),
        .exc_o        (exc_o),
        .exc_cause_o  (exc_cause_o),
        .exc_pc_o     (exc_pc_o),
        .byp_reg_i    (byp_reg_i),
        .byp_hit_o    (byp_hit_o),
        .byp_data_o   (byp_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order list of queued instructions plus a waiting-for-flush flag
    commit_entry_t mq[$];
    bit            m_wait = 1'b0;

    always @(negedge clk_i) begin : model_cmp
        logic                     e_ready, e_commit, e_wen, e_exc, retire;
        data_t                    e_cpc, e_wdata, e_cause, e_epc;
        reg_t                     e_wreg;
        logic [NRP-1:0]           e_hit;
        logic [NRP-1:0][XLEN-1:0] e_bdata;
        commit_entry_t            h;
        e_ready = 1'b0; e_commit = 1'b0; e_wen = 1'b0; e_exc = 1'b0; retire = 1'b0;
        e_cpc = '0; e_wdata = '0; e_cause = '0; e_epc = '0; e_wreg = '0;
        e_hit = '0; e_bdata = '0; h = '0;
        if (!rst_ni) begin
            mq.delete();
            m_wait = 1'b0;
        end else begin
            e_ready = !m_wait && (mq.size() < int'(DEPTH));
            retire  = !m_wait && (mq.size() != 0) && !debug_mode_i;
            if (retire) begin
                h = mq[0];
                if (h.exc) begin
                    e_exc = 1'b1; e_cause = h.cause; e_epc = h.pc;
                end else begin
                    e_commit = 1'b1; e_cpc = h.pc;
                    if (h.we && h.rd != 0) begin
                        e_wen = 1'b1; e_wreg = h.rd; e_wdata = h.result;
                    end
                end
            end
`ifdef COMMIT_QUEUE_BYPASS_EN
            for (int p = 0; p < int'(NRP); p++) begin
                for (int j = mq.size() - 1; j >= 0; j--) begin
                    if (!e_hit[p] && mq[j].we && !mq[j].exc && mq[j].rd != 0 &&
                        mq[j].rd == byp_reg_i[p]) begin
                        e_hit[p]   = 1'b1;
                        e_bdata[p] = mq[j].result;
                    end
                end
            end
`endif
        end
        chk("m_ready",     ready_o,     e_ready);
        chk("m_commit",    commit_o,    e_commit);
        chk("m_commit_pc", commit_pc_o, e_cpc);
        chk("m_w_en",      w_en_o,      e_wen);
        chk("m_w_reg",     w_reg_o,     e_wreg);
        chk("m_w_data",    w_data_o,    e_wdata);
        chk("m_exc",       exc_o,       e_exc);
        chk("m_exc_cause", exc_cause_o, e_cause);
        chk("m_exc_pc",    exc_pc_o,    e_epc);
        chk("m_byp_hit",   byp_hit_o,   e_hit);
        for (int p = 0; p < int'(NRP); p++) begin
            chk("m_byp_data", byp_data_o[p], e_bdata[p]);
        end
        if (rst_ni) begin
            if (flush_i) begin
                mq.delete();
                m_wait = 1'b0;
            end else begin
                if (retire) begin
                    void'(mq.pop_front());
                    if (h.exc) m_wait = 1'b1;
                end
                if (valid_i && e_ready) begin
                    mq.push_back('{pc: pc_i, we: we_i, rd: rd_i, result: result_i,
                                   exc: exc_i, cause: cause_i});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i = 1'b0; pc_i = '0; we_i = 1'b0; rd_i = '0;
        result_i = '0; exc_i = 1'b0; cause_i = '0;
    endtask

    task automatic put(input data_t pc, input logic we, input reg_t rd, input data_t res,
                       input logic exc, input data_t cause);
        valid_i = 1'b1; pc_i = pc; we_i = we; rd_i = rd;
        result_i = res; exc_i = exc; cause_i = cause;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rst_ni = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0;
        byp_reg_i[0] = 5'd7; byp_reg_i[1] = 5'd0; byp_reg_i[2] = 5'd5;

        // reset state
        tick();
        @(negedge clk_i);
        chk("rst_ready",  ready_o,  1'b0);
        chk("rst_commit", commit_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", ready_o, 1'b1);

        // single write to x5
        tick(); put(32'h100, 1'b1, 5'd5, 32'h1234, 1'b0, '0);
        tick(); idle();
        @(negedge clk_i);
        chk("x5_w_en",   w_en_o,      1'b1);
        chk("x5_w_reg",  w_reg_o,     5'd5);
        chk("x5_w_data", w_data_o,    32'h1234);
        chk("x5_commit", commit_o,    1'b1);
        chk("x5_pc",     commit_pc_o, 32'h100);

        // write to x0 commits without a register write
        tick(); put(32'h104, 1'b1, 5'd0, 32'hFF, 1'b0, '0);
        tick(); idle();
        @(negedge clk_i);
        chk("x0_commit", commit_o, 1'b1);
        chk("x0_w_en",   w_en_o,   1'b0);

        // fill under debug halt, then release
        tick(); debug_mode_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            put(32'h200 + 32'(4 * k), 1'b1, 5'(k + 1), 32'hA0 + 32'(k), 1'b0, '0);
            tick();
        end
        idle();
        @(negedge clk_i);
        chk("full_ready",  ready_o,  1'b0);
        chk("halt_commit", commit_o, 1'b0);
        tick(); debug_mode_i = 1'b0;
        @(negedge clk_i);
        chk("rel_pc0",    commit_pc_o, 32'h200);
        chk("rel_ready0", ready_o,     1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            @(negedge clk_i);
            chk("rel_pc", commit_pc_o, 32'h200 + 32'(4 * k));
            if (k == 1) chk("rel_ready1", ready_o, 1'b1);
        end

        // A ok, B faults, C never retires
        tick(); put(32'h300, 1'b1, 5'd9, 32'h33, 1'b0, '0);
        tick(); put(32'h304, 1'b1, 5'd10, 32'h44, 1'b1, 32'd2);
        @(negedge clk_i);
        chk("a_commit", commit_o,    1'b1);
        chk("a_pc",     commit_pc_o, 32'h300);
        tick(); put(32'h308, 1'b1, 5'd11, 32'h55, 1'b0, '0);
        @(negedge clk_i);
        chk("b_exc",       exc_o,       1'b1);
        chk("b_exc_cause", exc_cause_o, 32'd2);
        chk("b_exc_pc",    exc_pc_o,    32'h304);
        chk("b_commit",    commit_o,    1'b0);
        chk("b_w_en",      w_en_o,      1'b0);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("wait_ready",  ready_o,  1'b0);
            chk("wait_commit", commit_o, 1'b0);
            chk("wait_exc",    exc_o,    1'b0);
            tick();
        end
        flush_i = 1'b1;
        tick(); flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_ready",  ready_o,  1'b1);
        chk("flush_commit", commit_o, 1'b0);

        // full-rate streaming with two entries in flight, wrapping the pointers
        tick(); debug_mode_i = 1'b1;
        put(32'h400, 1'b1, 5'd1, 32'h400, 1'b0, '0); tick();
        put(32'h404, 1'b1, 5'd2, 32'h404, 1'b0, '0); tick();
        debug_mode_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            put(32'h408 + 32'(4 * k), 1'b1, 5'((k % 8) + 1), 32'h408 + 32'(4 * k), 1'b0, '0);
            @(negedge clk_i);
            chk("stream_pc",    commit_pc_o, 32'h400 + 32'(4 * k));
            chk("stream_ready", ready_o,     1'b1);
            tick();
        end
        idle();
        repeat (3) tick();

        // bypass: x7=1, x7=2, faulting x7=3
        debug_mode_i = 1'b1;
        put(32'h500, 1'b1, 5'd7, 32'd1, 1'b0, '0); tick();
        put(32'h504, 1'b1, 5'd7, 32'd2, 1'b0, '0); tick();
        put(32'h508, 1'b1, 5'd7, 32'd3, 1'b1, 32'd5); tick();
        idle();
        @(negedge clk_i);
`ifdef COMMIT_QUEUE_BYPASS_EN
        chk("byp7_hit",  byp_hit_o[0],  1'b1);
        chk("byp7_data", byp_data_o[0], 32'd2);
`else
        chk("byp7_hit",  byp_hit_o[0],  1'b0);
        chk("byp7_data", byp_data_o[0], 32'd0);
`endif
        chk("byp0_hit", byp_hit_o[1], 1'b0);
        tick(); debug_mode_i = 1'b0;
        repeat (4) tick();
        flush_i = 1'b1;
        tick(); flush_i = 1'b0;

        // reset in the middle of a stream
        for (int k = 0; k < 6; k++) begin
            put(32'h600 + 32'(4 * k), 1'b1, 5'd4, 32'(k + 1), 1'b0, '0);
            tick();
        end
        rst_ni = 1'b0;
        #1;
        chk("mrst_commit", commit_o,    1'b0);
        chk("mrst_pc",     commit_pc_o, 32'd0);
        chk("mrst_w_en",   w_en_o,      1'b0);
        chk("mrst_w_data", w_data_o,    32'd0);
        chk("mrst_exc",    exc_o,       1'b0);
        chk("mrst_ready",  ready_o,     1'b0);
        chk("mrst_hit",    byp_hit_o,   3'b000);
        idle();
        tick(); tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("mrst_rel_ready",  ready_o,  1'b1);
        chk("mrst_rel_commit", commit_o, 1'b0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
